// File: rtl/apb_master_bridge.sv
// APB3 master bridge from a single-outstanding core request bus; APB_TIMEOUT_EN adds an ACCESS watchdog.
// Response arrives 3 cycles after accept (zero-wait); req_ready is low from accept until the response cycle.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be in 2..65535");
    end

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic                    pwrite_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]             tmo_cnt_q;
`endif

    // Gated by reset so the core never sees ready while the bridge is held in reset.
    assign req_ready = PRESETN && (state_q == ST_IDLE);

    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            // Response fields are single-cycle; they fall back to zero unless set below.
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;

            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        paddr_q  <= req_addr;
                        pwrite_q <= req_we;
                        pwdata_q <= req_wdata;
                        if (req_addr[1:0] != 2'b00) begin
                            state_q     <= ST_ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_SETUP;
                            psel_q  <= 1'b1;
                        end
                    end
                end

                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= PSLVERR;
                        if (!pwrite_q && !PSLVERR) begin
                            rsp_rdata_q <= PRDATA;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
`endif
                end

                ST_ERR: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
